// File: rtl/regfile_pkg.sv
// Shared constants for the register file: default geometry, address width helper, reset value.
package regfile_pkg;

    localparam int unsigned WIDTH_DEFAULT = 32;
    localparam int unsigned DEPTH_DEFAULT = 32;

    // All storage and read-data registers clear to this bit pattern.
    localparam bit RESET_BIT = 1'b0;

    function automatic int unsigned addr_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    localparam int unsigned ADDR_W_DEFAULT = addr_w(DEPTH_DEFAULT);

endpackage

// File: rtl/register_file_if.sv
// Write port plus two ready/valid read ports of the register file.
interface register_file_if
    import regfile_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT,
    parameter int unsigned DEPTH = DEPTH_DEFAULT
);
    localparam int unsigned AW = addr_w(DEPTH);

    logic             wrenable;
    logic [AW-1:0]    wraddr;
    logic [WIDTH-1:0] wrdata;

    logic             rd_req_a,   rd_req_b;
    logic [AW-1:0]    rd_addr_a,  rd_addr_b;
    logic             rd_gnt_a,   rd_gnt_b;
    logic             rd_valid_a, rd_valid_b;
    logic [WIDTH-1:0] rd_data_a,  rd_data_b;
    logic             rd_ready_a, rd_ready_b;

    modport master (
        output wrenable, wraddr, wrdata,
        output rd_req_a, rd_addr_a, rd_ready_a,
        output rd_req_b, rd_addr_b, rd_ready_b,
        input  rd_gnt_a, rd_valid_a, rd_data_a,
        input  rd_gnt_b, rd_valid_b, rd_data_b
    );

    modport slave (
        input  wrenable, wraddr, wrdata,
        input  rd_req_a, rd_addr_a, rd_ready_a,
        input  rd_req_b, rd_addr_b, rd_ready_b,
        output rd_gnt_a, rd_valid_a, rd_data_a,
        output rd_gnt_b, rd_valid_b, rd_data_b
    );

endinterface

// File: rtl/regfile_rd_port.sv
// One read stage: accepts a request when empty or draining, holds the snapshot while stalled.
module regfile_rd_port
    import regfile_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req,
    input  logic             ready,
    input  logic [WIDTH-1:0] word,
    output logic             gnt,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    logic             valid_q;
    logic [WIDTH-1:0] data_q;

    assign gnt   = !valid_q || ready;
    assign valid = valid_q;
    assign data  = data_q;

    // data_q is cleared whenever the stage empties, so it reads zero while not valid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= {WIDTH{RESET_BIT}};
        end else if (req && gnt) begin
            valid_q <= 1'b1;
            data_q  <= word;
        end else if (gnt) begin
            valid_q <= 1'b0;
            data_q  <= {WIDTH{RESET_BIT}};
        end
    end

endmodule

// File: rtl/register_file.sv
// Register file, entry 0 hardwired to zero, one write port and two independent read stages.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to a matching read.
module register_file
    import regfile_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT,
    parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
    input  logic           clk,
    input  logic           reset,
    register_file_if.slave bus
);

    localparam int unsigned AW = addr_w(DEPTH);

    logic [WIDTH-1:0] mem  [1:DEPTH-1];
    logic [WIDTH-1:0] view [DEPTH];
    logic [DEPTH-1:1] we;
    logic [WIDTH-1:0] word_a, word_b;

    always_comb begin
        we = '0;
        for (int i = 1; i < DEPTH; i++) begin
            we[i] = bus.wrenable && (bus.wraddr == AW'(i));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 1; i < DEPTH; i++) mem[i] <= {WIDTH{RESET_BIT}};
        end else begin
            for (int i = 1; i < DEPTH; i++) begin
                if (we[i]) mem[i] <= bus.wrdata;
            end
        end
    end

    always_comb begin
        view[0] = '0;
        for (int i = 1; i < DEPTH; i++) view[i] = mem[i];
    end

`ifdef REGFILE_BYPASS_EN
    logic wr_live;
    assign wr_live = bus.wrenable && (bus.wraddr != '0);
    assign word_a  = (wr_live && bus.wraddr == bus.rd_addr_a) ? bus.wrdata : view[bus.rd_addr_a];
    assign word_b  = (wr_live && bus.wraddr == bus.rd_addr_b) ? bus.wrdata : view[bus.rd_addr_b];
`else
    assign word_a = view[bus.rd_addr_a];
    assign word_b = view[bus.rd_addr_b];
`endif

    regfile_rd_port #(.WIDTH(WIDTH)) u_port_a (
        .clk   (clk),
        .reset (reset),
        .req   (bus.rd_req_a),
        .ready (bus.rd_ready_a),
        .word  (word_a),
        .gnt   (bus.rd_gnt_a),
        .valid (bus.rd_valid_a),
        .data  (bus.rd_data_a)
    );

    regfile_rd_port #(.WIDTH(WIDTH)) u_port_b (
        .clk   (clk),
        .reset (reset),
        .req   (bus.rd_req_b),
        .ready (bus.rd_ready_b),
        .word  (word_b),
        .gnt   (bus.rd_gnt_b),
        .valid (bus.rd_valid_b),
        .data  (bus.rd_data_b)
    );

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file; expectations follow REGFILE_BYPASS_EN when defined.
module tb_register_file;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;

    register_file_if #(.WIDTH(32), .DEPTH(32)) bus ();

    register_file #(.WIDTH(32), .DEPTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write(input logic [4:0] addr, input logic [31:0] data);
        bus.wrenable = 1'b1;
        bus.wraddr   = addr;
        bus.wrdata   = data;
        step();
        bus.wrenable = 1'b0;
    endtask

    logic [31:0] bypass_exp;
    logic [31:0] stream_vals [4];

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset          = 1'b1;
        bus.wrenable   = 1'b0;
        bus.wraddr     = '0;
        bus.wrdata     = '0;
        bus.rd_req_a   = 1'b0;
        bus.rd_req_b   = 1'b0;
        bus.rd_addr_a  = '0;
        bus.rd_addr_b  = '0;
        bus.rd_ready_a = 1'b0;
        bus.rd_ready_b = 1'b0;
        stream_vals    = '{32'hA1, 32'hA2, 32'hA3, 32'hA4};

        // Reset state
        #12;
        check("rst_valid_a", {31'b0, bus.rd_valid_a}, 32'd0);
        check("rst_valid_b", {31'b0, bus.rd_valid_b}, 32'd0);
        check("rst_data_a", bus.rd_data_a, 32'd0);
        check("rst_data_b", bus.rd_data_b, 32'd0);
        check("rst_gnt_a", {31'b0, bus.rd_gnt_a}, 32'd1);
        reset = 1'b0;
        #1;

        // Write r5, then read it on A the very next cycle
        write(5'd5, 32'h90F7);
        bus.rd_req_a   = 1'b1;
        bus.rd_addr_a  = 5'd5;
        bus.rd_ready_a = 1'b1;
        step();
        bus.rd_req_a = 1'b0;
        check("r5_valid_a", {31'b0, bus.rd_valid_a}, 32'd1);
        check("r5_data_a", bus.rd_data_a, 32'h90F7);
        step();
        check("r5_drop_valid_a", {31'b0, bus.rd_valid_a}, 32'd0);
        check("r5_drop_data_a", bus.rd_data_a, 32'd0);

        // Writes to r0 are ignored; both ports read zero from the same address
        write(5'd0, 32'hFB50);
        bus.rd_req_a   = 1'b1;
        bus.rd_addr_a  = 5'd0;
        bus.rd_req_b   = 1'b1;
        bus.rd_addr_b  = 5'd0;
        bus.rd_ready_b = 1'b1;
        step();
        bus.rd_req_a = 1'b0;
        bus.rd_req_b = 1'b0;
        check("r0_valid_a", {31'b0, bus.rd_valid_a}, 32'd1);
        check("r0_valid_b", {31'b0, bus.rd_valid_b}, 32'd1);
        check("r0_data_a", bus.rd_data_a, 32'd0);
        check("r0_data_b", bus.rd_data_b, 32'd0);
        step();

        // Both ports read r5 together
        bus.rd_req_a  = 1'b1;
        bus.rd_addr_a = 5'd5;
        bus.rd_req_b  = 1'b1;
        bus.rd_addr_b = 5'd5;
        step();
        bus.rd_req_a = 1'b0;
        bus.rd_req_b = 1'b0;
        check("same_data_a", bus.rd_data_a, 32'h90F7);
        check("same_data_b", bus.rd_data_b, 32'h90F7);
        step();

        // Stalled read of r7 keeps its snapshot across a write to r7
        write(5'd7, 32'h1111);
        bus.rd_req_a   = 1'b1;
        bus.rd_addr_a  = 5'd7;
        bus.rd_ready_a = 1'b0;
        step();
        bus.wrenable = 1'b1;
        bus.wraddr   = 5'd7;
        bus.wrdata   = 32'h2222;
        for (int i = 0; i < 3; i++) begin
            check("stall_data_a", bus.rd_data_a, 32'h1111);
            check("stall_gnt_a", {31'b0, bus.rd_gnt_a}, 32'd0);
            check("stall_valid_a", {31'b0, bus.rd_valid_a}, 32'd1);
            step();
            bus.wrenable = 1'b0;
        end
        bus.rd_req_a   = 1'b0;
        bus.rd_ready_a = 1'b1;
        #1;
        check("stall_gnt_ready", {31'b0, bus.rd_gnt_a}, 32'd1);
        step();
        check("stall_release_valid", {31'b0, bus.rd_valid_a}, 32'd0);
        bus.rd_req_a = 1'b1;
        step();
        bus.rd_req_a = 1'b0;
        check("r7_after_write", bus.rd_data_a, 32'h2222);
        step();

        // Same-cycle write and read of r3
`ifdef REGFILE_BYPASS_EN
        bypass_exp = 32'hABCD;
`else
        bypass_exp = 32'h0;
`endif
        bus.wrenable  = 1'b1;
        bus.wraddr    = 5'd3;
        bus.wrdata    = 32'hABCD;
        bus.rd_req_a  = 1'b1;
        bus.rd_addr_a = 5'd3;
        step();
        bus.wrenable = 1'b0;
        check("bypass_data_a", bus.rd_data_a, bypass_exp);
        step();
        bus.rd_req_a = 1'b0;
        check("r3_landed", bus.rd_data_a, 32'hABCD);
        step();

        // Back-to-back stream r1..r4 on A while B stays idle
        for (int i = 0; i < 4; i++) write(5'(i + 1), stream_vals[i]);
        bus.rd_req_a  = 1'b1;
        bus.rd_addr_a = 5'd1;
        for (int i = 0; i < 4; i++) begin
            step();
            if (i == 3) bus.rd_req_a = 1'b0;
            bus.rd_addr_a = 5'(i + 2);
            check("stream_valid_a", {31'b0, bus.rd_valid_a}, 32'd1);
            check("stream_data_a", bus.rd_data_a, stream_vals[i]);
            check("stream_valid_b", {31'b0, bus.rd_valid_b}, 32'd0);
        end
        step();
        check("stream_end_valid_a", {31'b0, bus.rd_valid_a}, 32'd0);

        // Reset between edges while A is stalled on r5
        bus.rd_req_a   = 1'b1;
        bus.rd_addr_a  = 5'd5;
        bus.rd_ready_a = 1'b0;
        step();
        check("pre_rst_data_a", bus.rd_data_a, 32'h90F7);
        #2;
        reset = 1'b1;
        #1;
        check("midrst_valid_a", {31'b0, bus.rd_valid_a}, 32'd0);
        check("midrst_data_a", bus.rd_data_a, 32'd0);
        bus.rd_req_a   = 1'b0;
        bus.rd_ready_a = 1'b1;
        @(posedge clk);
        #2;
        reset = 1'b0;
        step();
        check("post_rst_no_pulse", {31'b0, bus.rd_valid_a}, 32'd0);
        for (int i = 1; i <= 7; i += 2) begin
            bus.rd_req_a  = 1'b1;
            bus.rd_addr_a = 5'(i);
            step();
            bus.rd_req_a = 1'b0;
            check("post_rst_entry", bus.rd_data_a, 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
